// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU through an IDLE/EXEC/RESP sequencer.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_ctrl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_ctrl,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero,
  output logic [1:0]   dbg_state,
  output logic         dbg_last_grant
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters hold valid and payload until accepted; the response holds until rsp_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [3:0]   op_ctrl;
  logic         op_id;
  logic         last_grant;

  logic         grant0;
  logic         grant1;
  logic         accept;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic [3:0]   sel_ctrl;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    // On contention the requester that did not win last time goes next.
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
`else
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
`endif
  end

  assign req0_ready = (state == IDLE) && !reset && grant0;
  assign req1_ready = (state == IDLE) && !reset && grant1;
  assign accept     = req0_ready || req1_ready;

  assign sel_a    = req1_ready ? req1_a    : req0_a;
  assign sel_b    = req1_ready ? req1_b    : req0_b;
  assign sel_ctrl = req1_ready ? req1_ctrl : req0_ctrl;

  // The shared ALU sees operands only during the single EXEC cycle.
  assign alu_a    = (state == EXEC) ? op_a    : '0;
  assign alu_b    = (state == EXEC) ? op_b    : '0;
  assign alu_ctrl = (state == EXEC) ? op_ctrl : 4'b0000;

  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= 4'b0000;
      op_id      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_ctrl <= sel_ctrl;
            op_id   <= req1_ready;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant <= req1_ready;
`endif
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus scoreboard; a monitor checks every response cycle.
module tb_alu_arbiter;
  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [N-1:0] rsp_result;
  logic [1:0]   dbg_state;
  logic         dbg_last_grant;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
  );

  function automatic logic [N-1:0] alu_f(input logic [N-1:0] x, input logic [N-1:0] y, input logic [3:0] k);
    case (k)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? N'(1) : N'(0);
      4'b1100: return ~(x | y);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  typedef struct {
    logic         id;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic [3:0]   ctrl;
    logic [N-1:0] res;
    logic         zero;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t h;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   n_accept = 0;
  int   n_resp = 0;
  bit   mon_en = 1'b0;
  logic model_last = 1'b1;
  logic rst_q = 1'b1;
  logic rr = 1'b1;

  logic         v[2];
  logic [N-1:0] a[2];
  logic [N-1:0] b[2];
  logic [3:0]   c[2];
  bit           sticky[2];
  logic [3:0]   ctrl_tab[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle's ALU drive and response against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("rsp_valid_none", 64'(rsp_valid), 64'd0);
        chk("alu_a_idle", 64'(alu_a), 64'd0);
        chk("alu_b_idle", 64'(alu_b), 64'd0);
        chk("alu_ctrl_idle", 64'(alu_ctrl), 64'd0);
      end else begin
        h = exp_q[0];
        if (cyc == h.acc + 1) begin
          chk("alu_a_exec", 64'(alu_a), 64'(h.opa));
          chk("alu_b_exec", 64'(alu_b), 64'(h.opb));
          chk("alu_ctrl_exec", 64'(alu_ctrl), 64'(h.ctrl));
        end else begin
          chk("alu_a_idle", 64'(alu_a), 64'd0);
          chk("alu_b_idle", 64'(alu_b), 64'd0);
          chk("alu_ctrl_idle", 64'(alu_ctrl), 64'd0);
        end
        if (cyc < h.acc + 2) begin
          chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
        end else begin
          chk("rsp_valid", 64'(rsp_valid), 64'd1);
          chk("rsp_id", 64'(rsp_id), 64'(h.id));
          chk("rsp_result", 64'(rsp_result), 64'(h.res));
          chk("rsp_zero", 64'(rsp_zero), 64'(h.zero));
          if (rsp_valid && rsp_ready) begin
            void'(exp_q.pop_front());
            n_resp <= n_resp + 1;
          end
        end
      end
    end
  end

  // One clock: drive inputs after the edge, then check readies and log any accept mid-cycle.
  task automatic step(output int acc);
    logic busy;
    int   w;
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst_q;
    req0_valid = v[0]; req0_a = a[0]; req0_b = b[0]; req0_ctrl = c[0];
    req1_valid = v[1]; req1_a = a[1]; req1_b = b[1]; req1_ctrl = c[1];
    rsp_ready  = rr;
    @(negedge clk);
    busy = (n_accept != n_resp) || rst_q;
    w = -1;
    if (!busy) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (v[0] && v[1]) w = (model_last == 1'b1) ? 0 : 1;
      else if (v[0]) w = 0;
      else if (v[1]) w = 1;
`else
      if (v[0]) w = 0;
      else if (v[1]) w = 1;
`endif
    end
    chk("req0_ready", 64'(req0_ready), 64'(w == 0));
    chk("req1_ready", 64'(req1_ready), 64'(w == 1));
    if (w >= 0) begin
      e.id   = w[0];
      e.opa  = a[w];
      e.opb  = b[w];
      e.ctrl = c[w];
      e.res  = alu_f(a[w], b[w], c[w]);
      e.zero = (e.res == '0);
      e.acc  = cyc;
      exp_q.push_back(e);
      n_accept++;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      model_last = w[0];
`endif
      if (!sticky[w]) v[w] = 1'b0;
    end
    acc = w;
  endtask

  task automatic do_reset(input int ncyc);
    int dummy;
    rst_q = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    sticky[0] = 1'b0; sticky[1] = 1'b0;
    repeat (ncyc) step(dummy);
    @(posedge clk);
    #1;
    rst_q = 1'b0; reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_q.delete();
    n_accept = n_resp;
    model_last = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("reset_last_grant", 64'(dbg_last_grant), 64'(model_last));
    chk("reset_req0_ready", 64'(req0_ready), 64'd0);
    chk("reset_req1_ready", 64'(req1_ready), 64'd0);
  endtask

  task automatic issue(input int id, input logic [N-1:0] x, input logic [N-1:0] y, input logic [3:0] k);
    int got;
    bit done;
    v[id] = 1'b1; a[id] = x; b[id] = y; c[id] = k;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(got);
      if (got == id) done = 1'b1;
    end
    if (!done) v[id] = 1'b0;
    chk("issue_accepted", 64'(done), 64'd1);
  endtask

  task automatic wait_idle();
    int got;
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 30 && !idle; i++) begin
      step(got);
      idle = (n_accept == n_resp);
    end
    chk("drain_done", 64'(idle), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int n;
    int order[4];
    int exp_order[4];

    ctrl_tab[0] = 4'b0000; ctrl_tab[1] = 4'b0001; ctrl_tab[2] = 4'b0010;
    ctrl_tab[3] = 4'b0110; ctrl_tab[4] = 4'b0111; ctrl_tab[5] = 4'b1100;
    for (int r = 0; r < 2; r++) begin
      v[r] = 1'b0; a[r] = '0; b[r] = '0; c[r] = 4'b0000; sticky[r] = 1'b0;
    end
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = 4'b0000;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = 4'b0000;

    do_reset(2);

    // Single add, then subtract-to-zero from requester 1.
    rr = 1'b1;
    issue(0, 64'd5, 64'd3, 4'b0010);
    wait_idle();
    issue(1, 64'h10, 64'h10, 4'b0110);
    wait_idle();

    // Backpressure: response held four cycles before the consumer takes it.
    rr = 1'b0;
    issue(0, 64'h1234, 64'h0ff0, 4'b0001);
    repeat (5) step(got);
    rr = 1'b1;
    wait_idle();

    // Reset while the accepted operation is in EXEC; it must vanish.
    issue(0, 64'd1, 64'd1, 4'b0010);
    do_reset(1);
    issue(1, 64'd7, 64'd9, 4'b0110);
    wait_idle();

    // Both requesters valid continuously.
    do_reset(1);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif
    a[0] = 64'hf0; b[0] = 64'h3c; c[0] = 4'b0000;
    a[1] = 64'hf0; b[1] = 64'h0f; c[1] = 4'b0001;
    v[0] = 1'b1; v[1] = 1'b1; sticky[0] = 1'b1; sticky[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      step(got);
      if (got >= 0) begin
        order[n] = got;
        n++;
      end
    end
    sticky[0] = 1'b0; sticky[1] = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
    chk("contention_grants", 64'(n), 64'd4);
    for (int k = 0; k < n; k++) chk($sformatf("grant_order_%0d", k), 64'(order[k]), 64'(exp_order[k]));
    wait_idle();
    chk("last_grant_after_contention", 64'(dbg_last_grant), 64'(model_last));

    // Randomized traffic with random consumer backpressure.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!v[r] && $urandom_range(0, 2) == 0) begin
          a[r] = {$urandom, $urandom};
          b[r] = {$urandom, $urandom};
          c[r] = ctrl_tab[$urandom_range(0, 5)];
          if ($urandom_range(0, 3) == 0) begin
            b[r] = a[r];
            c[r] = 4'b0110;
          end
          v[r] = 1'b1;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      step(got);
    end
    v[0] = 1'b0; v[1] = 1'b0; rr = 1'b1;
    wait_idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
